alu_issue: RTL and testbench

Request-side driver for the execute-stage ALU. It accepts one operation at a time from the decode/issue path over a valid/ready handshake and drives the ALU's op, operand and valid inputs. It tracks the ALU's variable latency (one cycle for most ops, two for ADD/SUB) using the ALU's `o_valid`, then returns the result with its tag to writeback over a second valid/ready handshake.

---
 rtl/alu_issue.sv | 155 +++++++++++++++
 tb/tb_alu_issue.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: single-issue request driver for the variable-latency execute ALU.
// Define ALU_ISSUE_DEPTH2_EN to replace the response register with a 2-entry FIFO.
module alu_issue #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [3:0]       i_req_op,
  input  logic [31:0]      i_req_a,
  input  logic [31:0]      i_req_b,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic [3:0]       o_alu_op,
  output logic [31:0]      o_alu_a,
  output logic [31:0]      o_alu_b,
  output logic             o_alu_valid,
  input  logic [31:0]      i_alu_out,
  input  logic             i_alu_valid,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_data,
  output logic [TAG_W-1:0] o_rsp_tag
);

  // Parked ALU op: XOR keeps the ALU out of its two-cycle ADD path.
  localparam logic [3:0] OpXor = 4'b0100;

  typedef enum logic [1:0] {StDrain, StIdle, StExec, StCapt} state_e;

  state_e           state_q, state_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic [3:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [TAG_W-1:0] tag_q;
  logic             accept, capture, rsp_pop;

  assign accept  = i_req_valid && o_req_ready;
  assign capture = (state_q == StCapt) && i_alu_valid;
  assign rsp_pop = o_rsp_valid && i_rsp_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StDrain;
      drain_cnt_q <= 2'd0;
      op_q        <= 4'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      if (accept) begin
        op_q  <= i_req_op;
        a_q   <= i_req_a;
        b_q   <= i_req_b;
        tag_q <= i_req_tag;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    o_alu_valid = 1'b0;
    o_alu_op    = OpXor;
    o_alu_a     = 32'd0;
    o_alu_b     = 32'd0;
    unique case (state_q)
      // Two cycles let any ADD left in the (unreset) ALU fall out unobserved.
      StDrain: begin
        drain_cnt_d = drain_cnt_q + 2'd1;
        if (drain_cnt_q == 2'd1) state_d = StIdle;
      end
      StIdle: begin
        if (accept) state_d = StExec;
      end
      StExec: begin
        o_alu_valid = 1'b1;
        o_alu_op    = op_q;
        o_alu_a     = a_q;
        o_alu_b     = b_q;
        state_d     = StCapt;
      end
      StCapt: begin
        o_alu_op = op_q;
        o_alu_a  = a_q;
        o_alu_b  = b_q;
        if (i_alu_valid) state_d = StIdle;
      end
      default: state_d = StDrain;
    endcase
  end

`ifdef ALU_ISSUE_DEPTH2_EN
  logic [31:0]      fifo_data_q [2];
  logic [TAG_W-1:0] fifo_tag_q  [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fifo_data_q[0] <= 32'd0;
      fifo_data_q[1] <= 32'd0;
      fifo_tag_q[0]  <= '0;
      fifo_tag_q[1]  <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      if (capture) begin
        fifo_data_q[wr_ptr_q] <= i_alu_out;
        fifo_tag_q[wr_ptr_q]  <= tag_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (rsp_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({capture, rsp_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A free slot at accept time guarantees the capture can never stall.
  assign o_req_ready = (state_q == StIdle) && (count_q != 2'd2);
  assign o_rsp_valid = (count_q != 2'd0);
  assign o_rsp_data  = fifo_data_q[rd_ptr_q];
  assign o_rsp_tag   = fifo_tag_q[rd_ptr_q];
`else
  logic             rsp_valid_q;
  logic [31:0]      rsp_data_q;
  logic [TAG_W-1:0] rsp_tag_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_tag_q   <= '0;
    end else if (capture) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= i_alu_out;
      rsp_tag_q   <= tag_q;
    end else if (rsp_pop) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign o_req_ready = (state_q == StIdle) && !rsp_valid_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_tag   = rsp_tag_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a behavioural variable-latency ALU.
// Runs the FIFO-specific cases when ALU_ISSUE_DEPTH2_EN is defined.
module tb_alu_issue;
  localparam int unsigned TAG_W = 5;

  logic             i_clk;
  logic             i_rst;
  logic             i_req_valid;
  logic             o_req_ready;
  logic [3:0]       i_req_op;
  logic [31:0]      i_req_a, i_req_b;
  logic [TAG_W-1:0] i_req_tag;
  logic [3:0]       o_alu_op;
  logic [31:0]      o_alu_a, o_alu_b;
  logic             o_alu_valid;
  logic [31:0]      i_alu_out;
  logic             i_alu_valid;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [31:0]      o_rsp_data;
  logic [TAG_W-1:0] o_rsp_tag;

  alu_issue #(.TAG_W(TAG_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_op    (i_req_op),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .i_req_tag   (i_req_tag),
    .o_alu_op    (o_alu_op),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_valid (o_alu_valid),
    .i_alu_out   (i_alu_out),
    .i_alu_valid (i_alu_valid),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_tag   (o_rsp_tag)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ALU model: one cycle for most ops, two for ADD/SUB; deliberately not reset.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op[2:0])
      3'b000:  return op[3] ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return {31'd0, $signed(a) < $signed(b)};
      3'b011:  return {31'd0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return op[3] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  logic        add_pend = 1'b0;
  logic [31:0] add_res  = 32'd0;
  initial begin
    i_alu_out   = 32'd0;
    i_alu_valid = 1'b0;
  end
  always @(posedge i_clk) begin
    add_pend <= o_alu_valid && (o_alu_op[2:0] == 3'b000);
    add_res  <= alu_f(o_alu_op, o_alu_a, o_alu_b);
    if (o_alu_valid && (o_alu_op[2:0] != 3'b000)) begin
      i_alu_valid <= 1'b1;
      i_alu_out   <= alu_f(o_alu_op, o_alu_a, o_alu_b);
    end else if (add_pend) begin
      i_alu_valid <= 1'b1;
      i_alu_out   <= add_res;
    end else begin
      i_alu_valid <= 1'b0;
    end
  end

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completed response handshake is matched against the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst && o_rsp_valid && i_rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got data 0x%0h tag %0d, expected no response",
                 o_rsp_data, o_rsp_tag);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_data", o_rsp_data, e.data);
        chk("rsp_tag", 32'(o_rsp_tag), 32'(e.tag));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Returns one cycle after the accepting edge, i.e. in the EXEC cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp, input bit push,
                       output int acc_cyc);
    int n = 0;
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_a     = a;
    i_req_b     = b;
    i_req_tag   = tag;
    while (!o_req_ready && n < 50) begin
      step(1);
      n++;
    end
    chk("req_accept", 32'(o_req_ready), 32'd1);
    acc_cyc = cyc;
    if (o_req_ready) begin
      if (push) sb_q.push_back('{data: exp, tag: tag});
      step(1);
    end
    i_req_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_req_ready"}, 32'(o_req_ready), 32'd0);
    chk({pfx, "_alu_valid"}, 32'(o_alu_valid), 32'd0);
    chk({pfx, "_alu_op"}, 32'(o_alu_op), 32'd4);
    chk({pfx, "_alu_a"}, o_alu_a, 32'd0);
    chk({pfx, "_alu_b"}, o_alu_b, 32'd0);
    chk({pfx, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    chk({pfx, "_rsp_data"}, o_rsp_data, 32'd0);
    chk({pfx, "_rsp_tag"}, 32'(o_rsp_tag), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int acc, acc2, n;
    i_rst       = 1'b1;
    i_req_valid = 1'b0;
    i_req_op    = 4'd0;
    i_req_a     = 32'd0;
    i_req_b     = 32'd0;
    i_req_tag   = '0;
    i_rsp_ready = 1'b1;
    #2;
    chk_reset_vals("por");
    step(2);
    i_rst = 1'b0;
    chk("drain0_ready", 32'(o_req_ready), 32'd0);
    step(1);
    chk("drain1_ready", 32'(o_req_ready), 32'd0);
    step(1);
    chk("idle_ready", 32'(o_req_ready), 32'd1);

    // XOR: one-cycle ALU latency, response at cycle 3.
    issue(4'b0100, 32'hF0F0_0000, 32'h0FF0_00FF, 5'd3, 32'hFF00_00FF, 1'b1, acc);
    chk("exec_alu_valid", 32'(o_alu_valid), 32'd1);
    chk("exec_alu_op", 32'(o_alu_op), 32'd4);
    chk("exec_alu_a", o_alu_a, 32'hF0F0_0000);
    chk("exec_alu_b", o_alu_b, 32'h0FF0_00FF);
    step(1);
    chk("capt_alu_valid", 32'(o_alu_valid), 32'd0);
    chk("capt_alu_a", o_alu_a, 32'hF0F0_0000);
    chk("xor_c2_rsp_valid", 32'(o_rsp_valid), 32'd0);
    step(1);
    chk("xor_c3_rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("xor_c3_rsp_data", o_rsp_data, 32'hFF00_00FF);
    step(1);
    chk("idle_alu_op", 32'(o_alu_op), 32'd4);
    chk("idle_alu_a", o_alu_a, 32'd0);

    // SUB: two-cycle ALU latency, response at cycle 4.
    issue(4'b1000, 32'd5, 32'd7, 5'd4, 32'hFFFF_FFFE, 1'b1, acc);
    step(2);
    chk("sub_c3_rsp_valid", 32'(o_rsp_valid), 32'd0);
    step(1);
    chk("sub_c4_rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("sub_c4_rsp_data", o_rsp_data, 32'hFFFF_FFFE);
    step(1);

    // Backpressure: response must hold while writeback stalls.
    i_rsp_ready = 1'b0;
    issue(4'b0000, 32'd1, 32'd2, 5'd5, 32'd3, 1'b1, acc);
    step(3);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 32'(o_rsp_valid), 32'd1);
      chk("hold_rsp_data", o_rsp_data, 32'd3);
      chk("hold_rsp_tag", 32'(o_rsp_tag), 32'd5);
`ifndef ALU_ISSUE_DEPTH2_EN
      chk("hold_req_ready", 32'(o_req_ready), 32'd0);
`endif
      step(1);
    end
    i_rsp_ready = 1'b1;
    step(1);
    chk("hold_released", 32'(o_rsp_valid), 32'd0);

    // Reset in the middle cycle of an ADD: no response, no stale result later.
    issue(4'b0000, 32'd1, 32'd2, 5'd6, 32'd3, 1'b0, acc);
    step(1);
    i_rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    step(1);
    i_rst = 1'b0;
    chk("mr_drain0_ready", 32'(o_req_ready), 32'd0);
    step(1);
    chk("mr_drain1_ready", 32'(o_req_ready), 32'd0);
    chk("mr_drain1_rsp_valid", 32'(o_rsp_valid), 32'd0);
    step(1);
    chk("mr_idle_ready", 32'(o_req_ready), 32'd1);
    issue(4'b0100, 32'hA, 32'h3, 5'd7, 32'h9, 1'b1, acc);
    step(2);
    chk("mr_xor_rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("mr_xor_rsp_data", o_rsp_data, 32'h9);
    step(1);

`ifdef ALU_ISSUE_DEPTH2_EN
    // Two responses queue up; a third request is held off.
    i_rsp_ready = 1'b0;
    issue(4'b0000, 32'd1, 32'd1, 5'd1, 32'd2, 1'b1, acc);
    issue(4'b0100, 32'd6, 32'd3, 5'd2, 32'd5, 1'b1, acc);
    step(2);
    i_req_valid = 1'b1;
    i_req_op    = 4'b0000;
    i_req_a     = 32'd9;
    i_req_b     = 32'd9;
    i_req_tag   = 5'd3;
    for (int i = 0; i < 4; i++) begin
      chk("fifo_full_ready", 32'(o_req_ready), 32'd0);
      step(1);
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    chk("fifo_head0_valid", 32'(o_rsp_valid), 32'd1);
    chk("fifo_head0_data", o_rsp_data, 32'd2);
    chk("fifo_head0_tag", 32'(o_rsp_tag), 32'd1);
    step(1);
    chk("fifo_head1_valid", 32'(o_rsp_valid), 32'd1);
    chk("fifo_head1_data", o_rsp_data, 32'd5);
    chk("fifo_head1_tag", 32'(o_rsp_tag), 32'd2);
    step(1);
    chk("fifo_empty", 32'(o_rsp_valid), 32'd0);
`endif

    // Streaming SLT then SLTU with writeback always ready.
    i_rsp_ready = 1'b1;
    issue(4'b0010, 32'hFFFF_FFFF, 32'd0, 5'd8, 32'd1, 1'b1, acc);
    issue(4'b0011, 32'hFFFF_FFFF, 32'd0, 5'd9, 32'd0, 1'b1, acc2);
`ifdef ALU_ISSUE_DEPTH2_EN
    chk("stream_spacing", 32'(acc2 - acc), 32'd3);
`else
    chk("stream_spacing", 32'(acc2 - acc), 32'd4);
`endif

    n = 0;
    while ((sb_q.size() != 0 || o_rsp_valid) && n < 50) begin
      step(1);
      n++;
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
